// File: rtl/icache_pkg.sv
// Shared types and address-field widths for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MISS   = 2'd2,
        FILL   = 2'd3
    } state_t;

    localparam int OFFSET_W       = 5;
    localparam int INDEX_W        = 4;
    localparam int TAG_W          = 23;
    localparam int WORDS_PER_LINE = 8;
    localparam int LINE_W         = 32 * WORDS_PER_LINE;

    function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                              input logic [2:0]        sel);
        return line[32*sel +: 32];
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Per-set tag and valid flops; combinational read, single write port, valid bits clear on rst.
module icache_tag_array
    import icache_pkg::*;
#(
    parameter int NUM_SETS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag
);

    logic [TAG_W-1:0]    tags [NUM_SETS];
    logic [NUM_SETS-1:0] valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tags need no reset: a tag is only ever compared behind its valid bit.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_index] <= wr_tag;
        end
    end

    assign rd_tag   = tags[rd_index];
    assign rd_valid = valid[rd_index];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped I-cache controller driving the external data array's single port.
// state | meaning: IDLE wait for fetch | LOOKUP tag compare, array data out | MISS await dfp line | FILL write line, respond
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int NUM_SETS  = 16,
    parameter int LINE_BITS = LINE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            ufp_addr,
    input  logic [3:0]             ufp_rmask,
    output logic                   ufp_ready,
    output logic [31:0]            ufp_rdata,
    output logic                   ufp_resp,
    output logic [31:0]            dfp_addr,
    output logic                   dfp_read,
    input  logic [LINE_BITS-1:0]   dfp_rdata,
    input  logic                   dfp_resp,
    output logic                   data_csb,
    output logic                   data_web,
    output logic [LINE_BITS/8-1:0] data_wmask,
    output logic [INDEX_W-1:0]     data_addr,
    output logic [LINE_BITS-1:0]   data_din,
    input  logic [LINE_BITS-1:0]   data_dout
);

    state_t               state, state_next;
    logic [TAG_W-1:0]     req_tag;
    logic [INDEX_W-1:0]   req_index;
    logic [2:0]           req_word;
    logic [LINE_BITS-1:0] line_buf;

    logic                 accept;
    logic                 hit;
    logic                 tag_we;
    logic [TAG_W-1:0]     rd_tag;
    logic                 rd_valid;
    logic                 unused_byte_offset;

    assign unused_byte_offset = ^ufp_addr[1:0];

    icache_tag_array #(.NUM_SETS(NUM_SETS)) u_tags (
        .clk      (clk),
        .rst      (rst),
        .rd_index (req_index),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .we       (tag_we),
        .wr_index (req_index),
        .wr_tag   (req_tag)
    );

    assign hit = (state == LOOKUP) && rd_valid && (rd_tag == req_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_tag   <= '0;
            req_index <= '0;
            req_word  <= '0;
            line_buf  <= '0;
        end else begin
            if (accept) begin
                req_tag   <= ufp_addr[31 -: TAG_W];
                req_index <= ufp_addr[OFFSET_W +: INDEX_W];
                req_word  <= ufp_addr[4:2];
            end
            if (state == MISS && dfp_resp) begin
                line_buf <= dfp_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        ufp_ready  = (state == IDLE) || hit;
        ufp_resp   = 1'b0;
        ufp_rdata  = '0;
        dfp_read   = 1'b0;
        dfp_addr   = '0;
        data_csb   = 1'b1;
        data_web   = 1'b1;
        data_wmask = '0;
        data_addr  = '0;
        data_din   = '0;
        tag_we     = 1'b0;

        accept = ufp_ready && (ufp_rmask != 4'h0) && !rst;

        // A newly accepted fetch starts its array read immediately, even mid-hit.
        if (accept) begin
            data_csb  = 1'b0;
            data_addr = ufp_addr[OFFSET_W +: INDEX_W];
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    ufp_resp   = 1'b1;
                    ufp_rdata  = line_word(data_dout, req_word);
                    state_next = accept ? LOOKUP : IDLE;
                end else begin
                    state_next = MISS;
                end
            end
            MISS: begin
                dfp_read = 1'b1;
                dfp_addr = {req_tag, req_index, {OFFSET_W{1'b0}}};
                if (dfp_resp) begin
                    tag_we     = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                data_csb   = 1'b0;
                data_web   = 1'b0;
                data_wmask = '1;
                data_addr  = req_index;
                data_din   = line_buf;
                ufp_resp   = 1'b1;
                ufp_rdata  = line_word(line_buf, req_word);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a behavioural data array, a line-fill responder and a response scoreboard.
module tb_icache_ctrl;

    logic         clk;
    logic         rst;
    logic [31:0]  ufp_addr;
    logic [3:0]   ufp_rmask;
    logic         ufp_ready;
    logic [31:0]  ufp_rdata;
    logic         ufp_resp;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic         data_csb;
    logic         data_web;
    logic [31:0]  data_wmask;
    logic [3:0]   data_addr;
    logic [255:0] data_din;
    logic [255:0] data_dout;

    icache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ufp_addr   (ufp_addr),
        .ufp_rmask  (ufp_rmask),
        .ufp_ready  (ufp_ready),
        .ufp_rdata  (ufp_rdata),
        .ufp_resp   (ufp_resp),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .data_csb   (data_csb),
        .data_web   (data_web),
        .data_wmask (data_wmask),
        .data_addr  (data_addr),
        .data_din   (data_din),
        .data_dout  (data_dout)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    int          cycle  = 0;
    int          dfp_cycles = 0;
    int          wr_count = 0;
    logic [31:0] last_wr_addr = 0;
    logic [31:0] last_wr_mask = 0;
    logic [31:0] last_dfp_addr = 0;
    bit          auto_dfp = 1;
    int          dfp_lat = 5;
    int          dfp_wait = 0;
    int          miss_lat;
    int          d0;
    int          w0;

    logic [255:0] sram [16];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle++;

    function automatic logic [31:0] mem_word(input logic [31:0] line_addr, input int w);
        if (line_addr == 32'h0000_1040 && w == 2) return 32'hDEAD_BEEF;
        if (line_addr == 32'h0000_1040 && w == 3) return 32'h1234_5678;
        return (line_addr << 4) ^ (32'h0101_0101 * 32'(w)) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word({a[31:5], 5'b0}, w);
        return l;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return mem_word({a[31:5], 5'b0}, int'(a[4:2]));
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Data array: registered inputs, write or read on each selected edge.
    initial for (int i = 0; i < 16; i++) sram[i] = {8{32'hBAD0_0000 | 32'(i)}};

    always @(posedge clk) begin
        if (!data_csb) begin
            if (!data_web) begin
                for (int b = 0; b < 32; b++)
                    if (data_wmask[b]) sram[data_addr][8*b +: 8] <= data_din[8*b +: 8];
            end else begin
                data_dout <= sram[data_addr];
            end
        end
    end

    // Memory side: answer a held dfp_read in its dfp_lat-th cycle.
    initial forever begin
        @(posedge clk); #1;
        if (auto_dfp) begin
            dfp_resp = 0;
            if (dfp_read && !rst) begin
                if (dfp_wait == dfp_lat - 1) begin
                    dfp_resp      = 1;
                    dfp_rdata     = line_of(dfp_addr);
                    last_dfp_addr = dfp_addr;
                    dfp_wait      = 0;
                end else begin
                    dfp_wait++;
                end
            end else begin
                dfp_wait = 0;
            end
        end else begin
            dfp_wait = 0;
        end
    end

    always @(negedge clk) begin
        if (ufp_resp) begin
            check1("resp_was_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check32("resp_rdata", ufp_rdata, e.data);
                check32("resp_cycle", 32'(cycle), 32'(e.cyc));
            end
        end
        if (!data_web) begin
            check1("write_selected", data_csb, 1'b0);
            wr_count++;
            last_wr_addr = 32'(data_addr);
            last_wr_mask = data_wmask;
        end
        if (dfp_read) dfp_cycles++;
    end

    task automatic issue(input logic [31:0] a, input int lat, input bit need_ready);
        int n = 0;
        if (!need_ready) begin
            while (!ufp_ready && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check1(need_ready ? "ready_held" : "ready_wait", ufp_ready, 1'b1);
        ufp_addr  = a;
        ufp_rmask = 4'hF;
        @(posedge clk); #1;
        ufp_rmask = 4'h0;
        if (lat >= 0) sb.push_back('{data: exp_word(a), cyc: cycle + lat});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check32("drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1;
        ufp_addr  = 0;
        ufp_rmask = 0;
        dfp_resp  = 0;
        dfp_rdata = '0;
        miss_lat  = dfp_lat + 1;
        repeat (3) @(posedge clk);
        #1;
        check1 ("rst_ready",    ufp_ready, 1'b1);
        check1 ("rst_resp",     ufp_resp,  1'b0);
        check32("rst_rdata",    ufp_rdata, 32'h0);
        check1 ("rst_dfp_read", dfp_read,  1'b0);
        check32("rst_dfp_addr", dfp_addr,  32'h0);
        check1 ("rst_csb",      data_csb,  1'b1);
        check1 ("rst_web",      data_web,  1'b1);
        check32("rst_wmask",    data_wmask, 32'h0);
        check32("rst_data_addr", 32'(data_addr), 32'h0);
        check1 ("rst_din_zero", |data_din, 1'b0);
        rst = 0;
        @(posedge clk); #1;

        // Cold miss
        w0 = wr_count;
        issue(32'h0000_1048, miss_lat, 0);
        drain();
        check32("cold_dfp_addr", last_dfp_addr, 32'h0000_1040);
        check32("cold_fill_writes", 32'(wr_count - w0), 32'd1);
        check32("cold_fill_index", last_wr_addr, 32'd2);
        check32("cold_fill_mask", last_wr_mask, 32'hFFFF_FFFF);

        // Single hit
        d0 = dfp_cycles;
        issue(32'h0000_104C, 0, 0);
        drain();
        check32("hit_no_dfp", 32'(dfp_cycles - d0), 32'd0);

        // Back-to-back hits across the whole line
        d0 = dfp_cycles;
        issue(32'h0000_1040, 0, 0);
        for (int i = 1; i < 8; i++) issue(32'h0000_1040 + 32'(4 * i), 0, 1);
        drain();
        check32("b2b_no_dfp", 32'(dfp_cycles - d0), 32'd0);

        // Conflict eviction and re-miss
        issue(32'h0000_1248, miss_lat, 0);
        drain();
        check32("conflict_dfp_addr", last_dfp_addr, 32'h0000_1240);
        issue(32'h0000_1048, miss_lat, 0);
        drain();
        check32("remiss_dfp_addr", last_dfp_addr, 32'h0000_1040);

        // Reset in the middle of a miss
        auto_dfp = 0;
        issue(32'h0000_2048, -1, 0);
        for (int n = 0; n < 20 && !dfp_read; n++) begin
            @(posedge clk); #1;
        end
        check1("abort_dfp_read_seen", dfp_read, 1'b1);
        @(posedge clk); #1;
        rst = 1;
        #1;
        check1("abort_dfp_read_drop", dfp_read, 1'b0);
        check1("abort_no_resp", ufp_resp, 1'b0);
        @(posedge clk); #1;
        dfp_resp  = 1;
        dfp_rdata = line_of(32'h0000_2040);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        dfp_resp = 0;
        check1("abort_idle_ready", ufp_ready, 1'b1);
        check1("abort_idle_dfp", dfp_read, 1'b0);
        auto_dfp = 1;
        @(posedge clk); #1;
        issue(32'h0000_1048, miss_lat, 0);
        drain();
        check32("post_reset_dfp_addr", last_dfp_addr, 32'h0000_1040);

        // Read issued in the cycle right after FILL
        d0 = dfp_cycles;
        issue(32'h0000_124C, miss_lat, 0);
        issue(32'h0000_1244, 0, 0);
        drain();
        check32("raf_one_miss", 32'(dfp_cycles - d0), 32'(dfp_lat));

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction-cache controller that acts as the initiator on the instruction cache data array's single read/write port. It serves fetch requests from the frontend on the ufp side, and fills missing lines from the memory arbiter on the dfp side. Tags and valid bits are kept in flops inside the block; line data lives in the external 16×256 data array.

## Interface
- NUM_SETS, 16, number of lines; must match the data-array depth.
- LINE_BITS, 256, line width; 32 bytes, 8 words.
- clk  in  1  clock; data array shares it.
- rst  in  1  asynchronous, active-high reset.
- ufp_addr  in  32  fetch byte address; bits [1:0] ignored.
- ufp_rmask  in  4  nonzero marks a request; one-cycle pulse.
- ufp_ready  out  1  block can accept a request this cycle.
- ufp_rdata  out  32  fetched word; valid only while ufp_resp is high.
- ufp_resp  out  1  one-cycle response strobe.
- dfp_addr  out  32  line-aligned fill address.
- dfp_read  out  1  fill request; held until dfp_resp.
- dfp_rdata  in  256  fill line data.
- dfp_resp  in  1  fill data valid.
- data_csb  out  1  data-array chip select, active low.
- data_web  out  1  data-array write enable, active low.
- data_wmask  out  32  byte write mask.
- data_addr  out  4  set index.
- data_din  out  256  write data.
- data_dout  in  256  read data; reflects the address captured at the previous edge.

## Operation
- Address split: offset [4:0], index [8:5], tag [31:9] (23 bits).
- Word select: word = line[32*addr[4:2] +: 32]. The full word is returned regardless of the rmask pattern.
- A request is accepted when ufp_rmask != 0 and ufp_ready = 1. A request presented while ufp_ready = 0 is ignored.
- ufp_ready = (state == IDLE) or (state == LOOKUP and hit).
- State machine:
  - IDLE: on accept, latch the address, drive data_csb=0, data_web=1, data_addr=index; go to LOOKUP.
  - LOOKUP: hit = valid[index] and tag match.
    - On hit: ufp_resp=1, ufp_rdata from data_dout. If a new request is accepted in the same cycle, issue its SRAM read and stay in LOOKUP; otherwise go to IDLE.
    - On miss: go to MISS.
  - MISS: dfp_read=1, dfp_addr={tag,index,5'b0}, both stable until dfp_resp. On dfp_resp: capture dfp_rdata into the line buffer, write tag, set valid[index]; go to FILL.
  - FILL: data_csb=0, data_web=0, data_wmask=32'hFFFF_FFFF, data_addr=index, data_din=line buffer. Also ufp_resp=1 with ufp_rdata taken from the line buffer. Go to IDLE.
- data_csb=1 in every cycle not listed above. data_wmask is 0 except in FILL.
- dfp_resp is ignored in every state other than MISS.
- Replacement: a conflicting tag overwrites the line; no write-back is needed.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, all valid bits cleared.
  - ufp_resp=0, ufp_ready=1, ufp_rdata=0.
  - dfp_read=0, dfp_addr=0.
  - data_csb=1, data_web=1, data_wmask=0, data_addr=0, data_din=0.
- Hit latency: ufp_resp arrives in the cycle after the accept edge. Sustained throughput is 1 hit per cycle.
- Miss latency: accept → LOOKUP (1 cycle) → MISS (N cycles, including the dfp_resp cycle) → FILL (1 cycle, response). Total is N+2 cycles after the accept edge.
- Data-array write completes at the second edge after FILL is driven. A read issued in the cycle after FILL must return the filled data; the array ordering guarantees this and the controller relies on it.
- The array keeps its last write registers while deselected, so a repeated identical write is benign. Idle cycles must not drive data_web=0.
- Reset during MISS: dfp_read drops asynchronously. A late dfp_resp is ignored. No ufp_resp is issued for the aborted request.

## Structure
- Package icache_pkg holds:
  - state enum {IDLE, LOOKUP, MISS, FILL};
  - constants OFFSET_W=5, INDEX_W=4, TAG_W=23, WORDS_PER_LINE=8.
- Sub-module icache_tag_array: NUM_SETS×(TAG_W+1) flops with one read port, one write port, and asynchronous valid clear on rst.
- The line buffer and state register live in icache_ctrl.

## Test plan
1. Cold miss: after reset, request 0x0000_1048 with rmask 4'hF.
   - Required: dfp_read=1 with dfp_addr=0x0000_1040.
   - Return dfp_resp after 5 cycles with word2=0xDEADBEEF.
   - Required: a FILL cycle with data_web=0, data_addr=2, data_wmask all ones, and ufp_resp with ufp_rdata=0xDEADBEEF.
2. Hit: request 0x0000_104C (word3=0x12345678).
   - Required: ufp_resp exactly 1 cycle after accept, rdata=0x12345678, dfp_read stays 0.
3. Back-to-back hits: 8 consecutive requests 0x1040..0x105C, one per cycle.
   - Required: 8 consecutive ufp_resp cycles returning words 0..7 in order, ufp_ready held high.
4. Conflict: request 0x0000_1248 (index 2, new tag).
   - Required: a miss with dfp_addr=0x0000_1240.
   - A following request to 0x0000_1048 then misses again.
5. Reset mid-miss: assert rst while dfp_read=1, then pulse dfp_resp.
   - Required: dfp_read=0 immediately, no ufp_resp.
   - A subsequent request to 0x1048 misses.
6. Read-after-fill: issue a request to the same line in the cycle after FILL.
   - Required: a hit returning the newly filled word, not stale array data.
